min_sys: RTL and testbench

//  Minimal I/O system top: debounced 4x4 keypad scanner, external-interrupt (EI) edge capture of
//  the 8-bit switch bank, and a 10-bit display control word driven to the VGA block.

---
 rtl/min_sys_if.sv | 19 +
 rtl/min_sys.sv | 138 +++++++++++++
 tb/tb_min_sys.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/min_sys_if.sv
// Board-side I/O bundle for min_sys: interrupt, switches, keypad matrix and display word.
// The master side drives the pins; the slave side is the min_sys block.
interface min_sys_if;
  logic       EI;
  logic [7:0] SW;
  logic [3:0] Keypad_rows;
  logic [3:0] Keypad_cols;
  logic [9:0] vga_cont;

  modport master (
    output EI, SW, Keypad_rows,
    input  Keypad_cols, vga_cont
  );

  modport slave (
    input  EI, SW, Keypad_rows,
    output Keypad_cols, vga_cont
  );
endinterface

// File: rtl/min_sys.sv
// Minimal I/O system: debounced 4x4 keypad scanner, EI rising-edge capture of the switch bank,
// and the {mode, val} display word for the VGA block.
module min_sys #(
  parameter int SCAN_DIV  = 4,
  parameter int DEB_SCANS = 2
) (
  input  logic     clk,
  input  logic     rst,
  min_sys_if.slave bus
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam int              DEB_W    = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_SCANS);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx;
  logic             r_ei_q;
  logic             r_scan_hit;
  logic [3:0]       r_scan_code;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [3:0]       r_deb_code;
  logic             r_last_valid;
  logic [3:0]       r_last_code;
  logic [1:0]       r_mode;
  logic [7:0]       r_val;

  logic             w_sample;
  logic             w_scan_end;
  logic             w_row_hit;
  logic [1:0]       w_row_idx;
  logic [3:0]       w_col_code;
  logic             w_res_valid;
  logic [3:0]       w_res_code;
  logic             w_ei_evt;
  logic             w_key_evt;
  logic [DEB_W-1:0] w_deb_cnt_nxt;
  logic [3:0]       w_deb_code_nxt;
  logic             w_last_valid_nxt;
  logic [3:0]       w_last_code_nxt;

  assign w_sample   = (r_div == DIV_LAST);
  assign w_scan_end = w_sample && (r_col_idx == 2'd3);
  assign w_row_hit  = ~&bus.Keypad_rows;
  assign w_col_code = {r_col_idx, w_row_idx};
  assign w_ei_evt   = bus.EI & ~r_ei_q;

  // Lowest active-low row wins; the loop runs high-to-low so the last match is the lowest.
  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.Keypad_rows[i]) w_row_idx = 2'(i);
    end
  end

  // Columns are scanned in ascending order, so the first hit recorded in a scan is the winner.
  assign w_res_valid = r_scan_hit | w_row_hit;
  assign w_res_code  = r_scan_hit ? r_scan_code : w_col_code;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_deb_cnt_nxt    = r_deb_cnt;
    w_deb_code_nxt   = r_deb_code;
    w_last_valid_nxt = r_last_valid;
    w_last_code_nxt  = r_last_code;
    w_key_evt        = 1'b0;
    if (w_scan_end) begin
      if (!w_res_valid) begin
        w_last_valid_nxt = 1'b0;
        w_deb_cnt_nxt    = '0;
      end else begin
        if (r_deb_cnt != '0 && w_res_code == r_deb_code) begin
          if (r_deb_cnt != DEB_MAX) w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end else begin
          w_deb_cnt_nxt  = DEB_W'(1);
          w_deb_code_nxt = w_res_code;
        end
        if (w_deb_cnt_nxt == DEB_MAX && !(r_last_valid && r_last_code == w_res_code)) begin
          w_key_evt        = 1'b1;
          w_last_valid_nxt = 1'b1;
          w_last_code_nxt  = w_res_code;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div        <= '0;
      r_col_idx    <= 2'd0;
      r_ei_q       <= 1'b0;
      r_scan_hit   <= 1'b0;
      r_scan_code  <= 4'h0;
      r_deb_cnt    <= '0;
      r_deb_code   <= 4'h0;
      r_last_valid <= 1'b0;
      r_last_code  <= 4'h0;
      r_mode       <= 2'b00;
      r_val        <= 8'h00;
    end else begin
      r_ei_q <= bus.EI;

      if (w_sample) begin
        r_div     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if (w_scan_end) begin
        r_scan_hit <= 1'b0;
      end else if (w_sample && w_row_hit && !r_scan_hit) begin
        r_scan_hit  <= 1'b1;
        r_scan_code <= w_col_code;
      end

      r_deb_cnt    <= w_deb_cnt_nxt;
      r_deb_code   <= w_deb_code_nxt;
      r_last_valid <= w_last_valid_nxt;
      r_last_code  <= w_last_code_nxt;

      // EI takes priority; a coincident key event is dropped but still marked as reported.
      if (w_ei_evt) begin
        r_mode <= 2'b01;
        r_val  <= bus.SW;
      end else if (w_key_evt) begin
        r_mode <= 2'b10;
        r_val  <= {4'h0, w_res_code};
      end
    end
  end

  assign bus.Keypad_cols = ~(4'b0001 << r_col_idx);
  assign bus.vga_cont    = {r_mode, r_val};

endmodule

// File: tb/tb_min_sys.sv
// Self-checking bench for min_sys: directed scenarios plus randomized keypad/EI/reset traffic,
// compared every cycle against a scan-position reference model of the keypad and event rules.
module tb_min_sys;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;
  localparam int SCAN_LEN  = 4 * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic [15:0] pressed;   // bit (col*4 + row) set = key physically pressed
  int          n_checks;
  int          n_errors;
  bit          mon_en;

  min_sys_if ifc();

  min_sys #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits in a column being driven low.
  always_comb begin
    logic [3:0] rows;
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (ifc.Keypad_cols[c] == 1'b0) rows = rows & ~pressed[c*4 +: 4];
    end
    ifc.Keypad_rows = rows;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: position in the scan is derived from cycles since reset; each column
  // is read at the end of its dwell and the scan result is the lowest pressed code seen.
  int unsigned m_t;
  logic        m_ei_q;
  logic [1:0]  m_mode;
  logic [7:0]  m_val;
  logic [3:0]  m_samp [4];
  int          m_cnt;
  int          m_code;
  bit          m_last_valid;
  int          m_last;

  initial begin : ref_model
    int p, c, code;
    bit ei_ev, key_ev;
    m_t = 0; m_ei_q = 0; m_mode = 0; m_val = 0;
    m_cnt = 0; m_code = 0; m_last_valid = 0; m_last = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_t = 0; m_ei_q = 0; m_mode = 2'b00; m_val = 8'h00;
        m_cnt = 0; m_code = 0; m_last_valid = 0; m_last = 0;
        for (int i = 0; i < 4; i++) m_samp[i] = 4'h0;
      end else begin
        ei_ev  = ifc.EI && !m_ei_q;
        m_ei_q = ifc.EI;
        key_ev = 0;
        code   = -1;
        p      = m_t % SCAN_LEN;
        if (p % SCAN_DIV == SCAN_DIV - 1) begin
          c = p / SCAN_DIV;
          m_samp[c] = pressed[c*4 +: 4];
          if (c == 3) begin
            for (int k = 15; k >= 0; k--) if (m_samp[k/4][k%4]) code = k;
            if (code < 0) begin
              m_last_valid = 0;
              m_cnt = 0;
            end else begin
              if (m_cnt > 0 && code == m_code) m_cnt++;
              else begin m_code = code; m_cnt = 1; end
              if (m_cnt >= DEB_SCANS && !(m_last_valid && m_last == code)) begin
                key_ev = 1; m_last_valid = 1; m_last = code;
              end
            end
          end
        end
        if (ei_ev) begin
          m_mode = 2'b01; m_val = ifc.SW;
        end else if (key_ev) begin
          m_mode = 2'b10; m_val = 8'(code);
        end
        m_t++;
      end
    end
  end

  initial begin : monitor
    logic [3:0] exp_cols;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_cols = ~(4'b0001 << ((m_t % SCAN_LEN) / SCAN_DIV));
        check("model_vga", 32'(ifc.vga_cont), 32'({m_mode, m_val}));
        check("model_cols", 32'(ifc.Keypad_cols), 32'(exp_cols));
      end
    end
  end

  initial begin : stim
    int r;
    n_checks = 0; n_errors = 0; mon_en = 0;
    rst = 1'b0; ifc.EI = 1'b0; ifc.SW = 8'h00; pressed = 16'h0000;

    // Reset state and column rotation
    cyc(1); mon_en = 1;
    cyc(1);
    check("rst_vga", 32'(ifc.vga_cont), 32'h000);
    check("rst_cols", 32'(ifc.Keypad_cols), 32'hE);
    rst = 1'b1;
    cyc(3);  check("col0", 32'(ifc.Keypad_cols), 32'hE);
    cyc(1);  check("col1", 32'(ifc.Keypad_cols), 32'hD);
    cyc(4);  check("col2", 32'(ifc.Keypad_cols), 32'hB);
    cyc(4);  check("col3", 32'(ifc.Keypad_cols), 32'h7);
    cyc(4);  check("col_wrap", 32'(ifc.Keypad_cols), 32'hE);

    // EI high through reset fires once on the first post-reset edge
    rst = 1'b0; ifc.EI = 1'b1; ifc.SW = 8'd50;
    cyc(2);  check("ei_rst_vga", 32'(ifc.vga_cont), 32'h000);
    rst = 1'b1;
    cyc(1);  check("ei_first", 32'(ifc.vga_cont), 32'h132);
    cyc(20); check("ei_level", 32'(ifc.vga_cont), 32'h132);
    ifc.EI = 1'b0;
    cyc(1);  ifc.EI = 1'b1; ifc.SW = 8'hFF;
    cyc(1);  check("ei_edge", 32'(ifc.vga_cont), 32'h1FF);

    // No keys, EI level held, switches wandering: nothing changes
    for (int i = 0; i < 100; i++) begin
      ifc.SW = 8'($urandom);
      cyc(1);
    end
    check("idle", 32'(ifc.vga_cont), 32'h1FF);

    // col2 row1 -> code 9, single event while held, new event after release
    pressed = 16'h0200;
    cyc(48);  check("key9", 32'(ifc.vga_cont), 32'h209);
    ifc.EI = 1'b0; cyc(1); ifc.EI = 1'b1; ifc.SW = 8'h3C;
    cyc(1);   check("ei_mid_hold", 32'(ifc.vga_cont), 32'h13C);
    cyc(9 * SCAN_LEN); check("no_repeat", 32'(ifc.vga_cont), 32'h13C);
    pressed = 16'h0000;
    cyc(SCAN_LEN);
    ifc.EI = 1'b0; cyc(1); ifc.EI = 1'b1; ifc.SW = 8'h11;
    cyc(1);   check("ei_release", 32'(ifc.vga_cont), 32'h111);
    pressed = 16'h0200;
    cyc(48);  check("repress", 32'(ifc.vga_cont), 32'h209);

    // Glitch of one scan is rejected; two keys resolve to the lowest column
    pressed = 16'h0000; ifc.EI = 1'b0;
    cyc(1);   ifc.EI = 1'b1; ifc.SW = 8'h22;
    cyc(1);   check("ei_pre_glitch", 32'(ifc.vga_cont), 32'h122);
    cyc(30);
    pressed = 16'h0200;
    cyc(SCAN_LEN);
    pressed = 16'h0000;
    cyc(64);  check("glitch", 32'(ifc.vga_cont), 32'h122);
    pressed = 16'h0180;
    cyc(48);  check("two_keys", 32'(ifc.vga_cont), 32'h207);
    pressed = 16'h0000;

    // EI and key event on the same edge: EI wins and the key is still consumed
    rst = 1'b0; ifc.EI = 1'b0; pressed = 16'h0001;
    cyc(2);
    rst = 1'b1;
    cyc(2 * SCAN_LEN - 1); check("pre_collide", 32'(ifc.vga_cont), 32'h000);
    ifc.EI = 1'b1; ifc.SW = 8'hA5;
    cyc(1);   check("collide", 32'(ifc.vga_cont), 32'h1A5);
    cyc(40);  check("collide_hold", 32'(ifc.vga_cont), 32'h1A5);

    // Reset in the middle of a debounce forces a full re-debounce
    pressed = 16'h0000; ifc.EI = 1'b0;
    cyc(20);
    pressed = 16'h0040;
    cyc(20);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_vga", 32'(ifc.vga_cont), 32'h000);
    check("mid_rst_cols", 32'(ifc.Keypad_cols), 32'hE);
    rst = 1'b1;
    cyc(24);  check("redebounce_wait", 32'(ifc.vga_cont), 32'h000);
    cyc(10);  check("redebounce_done", 32'(ifc.vga_cont), 32'h206);

    // Randomized traffic checked by the reference model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      ifc.SW = 8'($urandom);
      if ($urandom_range(0, 5) == 0) ifc.EI = ~ifc.EI;
      if ($urandom_range(0, 49) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)      pressed = 16'h0000;
        else if (r < 8) pressed = 16'h0001 << $urandom_range(0, 15);
        else            pressed = (16'h0001 << $urandom_range(0, 15)) |
                                  (16'h0001 << $urandom_range(0, 15));
      end
    end
    rst = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
